msg_create_scheduler: RTL and testbench

Sequences outbound session-message orders (logon, logout, heartbeat, resendReq, etc.) into the single shared message-creation engine. Two requesters feed it: the receive-driven session path and the session-control path (connect / end-session / timeout). It round-robin arbitrates them into a small FIFO, then issues one order at a time to the creator with a start/done handshake. A new order is held while the creator is busy, and a watchdog drops orders the creator never completes.

---
 rtl/fix_msg_pkg.sv | 40 ++++
 rtl/msg_req_fifo.sv | 63 ++++++
 rtl/msg_create_scheduler.sv | 160 ++++++++++++++++
 tb/tb_msg_create_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_msg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fix_msg_pkg
// Description : Shared message-type codes, order entry layout and dispatcher
//               state encoding for the session message-creation scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package fix_msg_pkg;

    localparam int c_HOST_W   = 10;
    localparam int c_COMPID_W = 256;

    localparam logic [3:0] c_MSG_LOGON     = 4'd1;
    localparam logic [3:0] c_MSG_HEARTBEAT = 4'd2;
    localparam logic [3:0] c_MSG_RESENDREQ = 4'd3;
    localparam logic [3:0] c_MSG_LOGOUT    = 4'd4;
    localparam logic [3:0] c_MSG_RESET     = 4'd5;
    localparam logic [3:0] c_MSG_GAPFILL   = 4'd6;
    localparam logic [3:0] c_MSG_BUSINESS  = 4'd7;

    typedef struct packed {
        logic [3:0]            msg_type;
        logic [c_HOST_W-1:0]   host;
        logic [c_COMPID_W-1:0] compid;
    } order_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } disp_state_t;

    function automatic logic is_legal_type(input logic [3:0] t);
        return t inside {c_MSG_LOGON, c_MSG_HEARTBEAT, c_MSG_RESENDREQ,
                         c_MSG_LOGOUT, c_MSG_RESET, c_MSG_GAPFILL,
                         c_MSG_BUSINESS};
    endfunction

endpackage
`default_nettype wire

// File: rtl/msg_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : msg_req_fifo
// Description : Synchronous FIFO with clear, full/empty flags and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module msg_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    // A push while full is refused even if a pop happens in the same cycle.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop_ok)
                r_count <= r_count + 1'b1;
            else if (w_pop_ok && !w_push_ok)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/msg_create_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : msg_create_scheduler
// Description : Round-robin merges rx-path and control-path message orders
//               into a queue and dispatches them to the message creator.
// Revision    : 1.0 - initial release
// ============================================================================
module msg_create_scheduler
    import fix_msg_pkg::*;
#(
    parameter int NUM_HOST     = c_HOST_W,
    parameter int VALUE_WIDTH  = c_COMPID_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           a_valid_i,
    output logic                           a_ready_o,
    input  logic [3:0]                     a_type_i,
    input  logic [NUM_HOST-1:0]            a_host_i,
    input  logic [VALUE_WIDTH-1:0]         a_compid_i,
    input  logic                           b_valid_i,
    output logic                           b_ready_o,
    input  logic [3:0]                     b_type_i,
    input  logic [NUM_HOST-1:0]            b_host_i,
    input  logic [VALUE_WIDTH-1:0]         b_compid_i,
    input  logic                           flush_i,
    input  logic                           cm_ready_i,
    input  logic                           cm_done_i,
    output logic                           cm_start_o,
    output logic [3:0]                     cm_type_o,
    output logic [NUM_HOST-1:0]            cm_host_o,
    output logic [VALUE_WIDTH-1:0]         cm_compid_o,
    output logic                           invalid_o,
    output logic                           timeout_o,
    output logic [$clog2(FIFO_DEPTH):0]    level_o
);
    localparam int              WD_W      = $clog2(DONE_TIMEOUT);
    localparam logic [WD_W-1:0] c_WD_LAST = WD_W'(DONE_TIMEOUT - 1);

    logic        r_rr_b;
    logic        r_invalid;
    logic        r_timeout;
    logic        r_start;
    disp_state_t r_state;
    logic [WD_W-1:0] r_wd;
    order_t      r_cm;

    logic        w_full;
    logic        w_empty;
    logic        w_acc_a;
    logic        w_acc_b;
    logic        w_acc;
    logic        w_legal;
    logic        w_push;
    logic        w_pop;
    logic [WD_W-1:0] w_wd_next;
    order_t      w_in;
    order_t      w_head;

    // ---------------- arbiter and type check ----------------
    assign a_ready_o = !w_full && !flush_i && (!b_valid_i || !r_rr_b);
    assign b_ready_o = !w_full && !flush_i && (!a_valid_i ||  r_rr_b);
    assign w_acc_a   = a_valid_i && a_ready_o;
    assign w_acc_b   = b_valid_i && b_ready_o;
    assign w_acc     = w_acc_a || w_acc_b;

    assign w_in.msg_type = w_acc_a ? a_type_i   : b_type_i;
    assign w_in.host     = w_acc_a ? a_host_i   : b_host_i;
    assign w_in.compid   = w_acc_a ? a_compid_i : b_compid_i;

    assign w_legal = is_legal_type(w_in.msg_type);
    assign w_push  = w_acc && w_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_b    <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_invalid <= w_acc && !w_legal;
            // Only a contended accept hands priority to the other port.
            if (a_valid_i && b_valid_i && w_acc)
                r_rr_b <= !r_rr_b;
        end
    end

    msg_req_fifo #(
        .WIDTH (($bits(order_t))),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_in),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level_o)
    );

    // ---------------- dispatcher and watchdog ----------------
    assign w_pop     = (r_state == ST_IDLE) && !w_empty && cm_ready_i && !flush_i;
    assign w_wd_next = r_wd + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            r_wd      <= '0;
            r_cm      <= '0;
        end else begin
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            if (flush_i) begin
                r_state <= ST_IDLE;
                r_wd    <= '0;
                r_cm    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_pop) begin
                            r_cm    <= w_head;
                            r_wd    <= '0;
                            r_start <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        r_state <= cm_done_i ? ST_IDLE : ST_WAIT;
                    end
                    ST_WAIT: begin
                        // Completion wins over a watchdog expiry in the same cycle.
                        if (cm_done_i) begin
                            r_state <= ST_IDLE;
                        end else if (w_wd_next == c_WD_LAST) begin
                            r_state   <= ST_IDLE;
                            r_timeout <= 1'b1;
                        end else begin
                            r_wd <= w_wd_next;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign cm_start_o  = r_start;
    assign cm_type_o   = r_cm.msg_type;
    assign cm_host_o   = r_cm.host;
    assign cm_compid_o = r_cm.compid;
    assign invalid_o   = r_invalid;
    assign timeout_o   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_msg_create_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_msg_create_scheduler
// Description : Directed and random stimulus against a queue-based model of
//               the order scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msg_create_scheduler;
    localparam int NH    = 10;
    localparam int VW    = 256;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [3:0]    a_type = '0, b_type = '0;
    logic [NH-1:0] a_host = '0, b_host = '0;
    logic [VW-1:0] a_compid = '0, b_compid = '0;
    logic          flush = 1'b0, cm_ready = 1'b0, cm_done = 1'b0;

    logic          a_ready, b_ready, cm_start, invalid, timeout;
    logic [3:0]    cm_type;
    logic [NH-1:0] cm_host;
    logic [VW-1:0] cm_compid;
    logic [2:0]    level;

    always #5 clk = ~clk;

    msg_create_scheduler #(
        .NUM_HOST(NH), .VALUE_WIDTH(VW), .FIFO_DEPTH(DEPTH), .DONE_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_type_i(a_type),
        .a_host_i(a_host), .a_compid_i(a_compid),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_type_i(b_type),
        .b_host_i(b_host), .b_compid_i(b_compid),
        .flush_i(flush), .cm_ready_i(cm_ready), .cm_done_i(cm_done),
        .cm_start_o(cm_start), .cm_type_o(cm_type), .cm_host_o(cm_host),
        .cm_compid_o(cm_compid), .invalid_o(invalid), .timeout_o(timeout),
        .level_o(level)
    );

    typedef struct {
        logic [3:0]    t;
        logic [NH-1:0] h;
        logic [VW-1:0] c;
    } ord_t;

    // Model: the queue holds accepted legal orders not yet handed out; the
    // creator is "busy" from the start pulse until done or TMO busy cycles.
    ord_t q[$];
    ord_t cur;
    bit   busy = 0;
    bit   pref_b = 0;
    bit   fields_known = 1;
    int   age = 0;
    int   done_mode = 0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] rnd_compid();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic set_a(input logic v, input logic [3:0] t, input logic [NH-1:0] h);
        a_valid = v; a_type = t; a_host = h; a_compid = rnd_compid();
    endtask

    task automatic set_b(input logic v, input logic [3:0] t, input logic [NH-1:0] h);
        b_valid = v; b_type = t; b_host = h; b_compid = rnd_compid();
    endtask

    task automatic model_reset();
        q.delete();
        busy = 0; pref_b = 0; age = 0; fields_known = 1;
        cur = '{t: '0, h: '0, c: '0};
    endtask

    // One clock: check readies, advance the model across the edge, check outputs.
    task automatic cycle();
        bit   full, ar, br, acc_a, acc_b, exp_start, exp_to, exp_inv;
        ord_t o;
        case (done_mode)
            0:       cm_done = busy;
            1:       cm_done = 1'b0;
            default: cm_done = ($urandom_range(0, 3) == 0);
        endcase
        #1;
        full = (q.size() == DEPTH);
        ar = !full && !flush && (!b_valid || !pref_b);
        br = !full && !flush && (!a_valid ||  pref_b);
        chk("a_ready", VW'(a_ready), VW'(ar));
        chk("b_ready", VW'(b_ready), VW'(br));
        acc_a = a_valid && ar;
        acc_b = b_valid && br;
        @(posedge clk);
        exp_start = 0; exp_to = 0; exp_inv = 0;
        if (flush) begin
            q.delete();
            busy = 0;
            cur = '{t: '0, h: '0, c: '0};
            fields_known = 1;
        end else begin
            if (busy) begin
                age++;
                if (cm_done) begin
                    busy = 0; fields_known = 0;
                end else if (age == TMO) begin
                    busy = 0; fields_known = 0; exp_to = 1;
                end
            end else if (q.size() != 0 && cm_ready) begin
                cur = q.pop_front();
                busy = 1; age = 0; exp_start = 1; fields_known = 1;
            end
            if (acc_a || acc_b) begin
                o.t = acc_a ? a_type   : b_type;
                o.h = acc_a ? a_host   : b_host;
                o.c = acc_a ? a_compid : b_compid;
                if (o.t >= 4'd1 && o.t <= 4'd7) q.push_back(o);
                else exp_inv = 1;
                if (a_valid && b_valid) pref_b = !pref_b;
            end
        end
        #1;
        chk("cm_start", VW'(cm_start), VW'(exp_start));
        chk("timeout",  VW'(timeout),  VW'(exp_to));
        chk("invalid",  VW'(invalid),  VW'(exp_inv));
        chk("level",    VW'(level),    VW'(q.size()));
        if (fields_known) begin
            chk("cm_type",   VW'(cm_type), VW'(cur.t));
            chk("cm_host",   VW'(cm_host), VW'(cur.h));
            chk("cm_compid", cm_compid,    cur.c);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"},   VW'(cm_start),  '0);
        chk({tag, "_timeout"}, VW'(timeout),   '0);
        chk({tag, "_invalid"}, VW'(invalid),   '0);
        chk({tag, "_level"},   VW'(level),     '0);
        chk({tag, "_type"},    VW'(cm_type),   '0);
        chk({tag, "_host"},    VW'(cm_host),   '0);
        chk({tag, "_compid"},  cm_compid,      '0);
    endtask

    initial begin
        model_reset();
        // Reset state: outputs zero, both ports may accept.
        #1;
        chk_all_zero("rst");
        chk("rst_a_ready", VW'(a_ready), VW'(1));
        chk("rst_b_ready", VW'(b_ready), VW'(1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single order from A: start two cycles after accept, done in ISSUE.
        cm_ready = 1'b1; done_mode = 0;
        set_a(1'b1, 4'd1, 10'd3);
        cycle();
        a_valid = 1'b0;
        repeat (4) cycle();

        // Contention with creator not ready: A,B,A,B then full.
        cm_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 4'($urandom_range(1, 7)), NH'($urandom));
            set_b(1'b1, 4'($urandom_range(1, 7)), NH'($urandom));
            cycle();
        end
        chk("level_full", VW'(level), VW'(DEPTH));
        repeat (2) cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        cm_ready = 1'b1;
        repeat (12) cycle();

        // Illegal types from B: accepted, flagged, never queued.
        set_b(1'b1, 4'd0, 10'd5);
        cycle();
        b_valid = 1'b0;
        cycle();
        set_b(1'b1, 4'd9, 10'd6);
        cycle();
        b_valid = 1'b0;
        repeat (3) cycle();

        // Creator never completes: both orders are abandoned by the watchdog.
        done_mode = 1;
        set_a(1'b1, 4'd2, 10'd7);
        cycle();
        set_a(1'b1, 4'd3, 10'd8);
        cycle();
        a_valid = 1'b0;
        repeat (22) cycle();

        // Flush with one order in WAIT and three queued, A requesting.
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 4'($urandom_range(1, 7)), NH'($urandom));
            cycle();
        end
        a_valid = 1'b0;
        cycle();
        flush = 1'b1;
        set_a(1'b1, 4'd4, 10'd9);
        cycle();
        flush = 1'b0; a_valid = 1'b0;
        chk("flush_level", VW'(level), '0);
        repeat (3) cycle();

        // Async reset during WAIT, then normal operation resumes.
        set_a(1'b1, 4'd5, 10'd11);
        cycle();
        a_valid = 1'b0;
        repeat (3) cycle();
        #3 rst = 1'b1;
        #1;
        chk_all_zero("arst");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        done_mode = 0;
        set_a(1'b1, 4'd6, 10'd12);
        cycle();
        a_valid = 1'b0;
        repeat (4) cycle();

        // Random traffic, then drain.
        done_mode = 2;
        for (int i = 0; i < 300; i++) begin
            set_a(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), NH'($urandom));
            set_b(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), NH'($urandom));
            cm_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 49) == 0);
            cycle();
        end
        a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0;
        cm_ready = 1'b1; done_mode = 0;
        repeat (20) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
